// File: rtl/fifo_pkg.sv
// Shared constants, width helper and count type for the fifo_buffer block.
// Optional error flags are enabled with `define FIFO_ERR_FLAGS_EN.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    typedef logic [clog2(DEF_DEPTH):0] count_t;

endpackage

// File: rtl/fifo_buffer_if.sv
// Write/read strobes and status bundle between fifo_buffer and its user.
// overflow/underflow exist only when FIFO_ERR_FLAGS_EN is defined.
interface fifo_buffer_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int ADDR_W = clog2(DEPTH);

    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic              ren;
    logic [DATA_W-1:0] rdata;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
    logic              overflow;
    logic              underflow;
`endif

    modport master (
        output wen, wdata, ren,
        input  rdata, empty, full, almost_full, count
`ifdef FIFO_ERR_FLAGS_EN
        , input overflow, underflow
`endif
    );

    modport slave (
        input  wen, wdata, ren,
        output rdata, empty, full, almost_full, count
`ifdef FIFO_ERR_FLAGS_EN
        , output overflow, underflow
`endif
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read.
// Contents are never reset; occupancy tracking lives in fifo_buffer.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_buffer.sv
// Circular-buffer FIFO storage with show-ahead head word and count-based status.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_buffer
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic           clk,
    input  logic           rstn,
    fifo_buffer_if.slave   bus
);

    localparam int ADDR_W = clog2(DEPTH);

    typedef logic [ADDR_W:0]   cnt_t;
    typedef logic [ADDR_W-1:0] ptr_t;

    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    cnt_t count_q, count_d;

    logic empty, full;
    logic wr_ok, rd_ok;

    // Status comes from the registered count only, so full/empty are pre-edge.
    assign empty = (count_q == '0);
    assign full  = (count_q == cnt_t'(DEPTH));
    assign wr_ok = bus.wen & ~full;
    assign rd_ok = bus.ren & ~empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_ok) wptr_d = wptr_q + ptr_t'(1);
        if (rd_ok) rptr_d = rptr_q + ptr_t'(1);
        if (wr_ok && !rd_ok) count_d = count_q + cnt_t'(1);
        else if (rd_ok && !wr_ok) count_d = count_q - cnt_t'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_ok & rstn),
        .waddr_i (wptr_q),
        .wdata_i (bus.wdata),
        .raddr_i (rptr_q),
        .rdata_o (bus.rdata)
    );

    assign bus.count       = count_q;
    assign bus.empty       = empty;
    assign bus.full        = full;
    assign bus.almost_full = (count_q >= cnt_t'(AF_LEVEL));

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q | (bus.wen & full);
        unf_d = unf_q | (bus.ren & empty);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`endif

endmodule
